muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width; the block SHALL support only WIDTH=32.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  in  1  issue a multiply/divide op this cycle.
REQ-005 op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start.
REQ-006 rs_data  in  32  multiplicand/dividend; sampled with start.
REQ-007 rt_data  in  32  multiplier/divisor; sampled with start.
REQ-008 mf_rd  in  1  MFHI/MFLO request from the execute stage.
REQ-009 mt_we  in  1  MTHI/MTLO write request.
REQ-010 hl_sel  in  1  0=LO, 1=HI; selects the target for mf_rd and mt_we.
REQ-011 mt_data  in  32  write data for mt_we.
REQ-012 hl_rdata  out  32  combinational read of the HI/LO register selected by hl_sel.
REQ-013 busy  out  1  an operation is in flight.
REQ-014 stall  out  1  pipeline hold request.
REQ-015 done  out  1  one-cycle pulse when HI/LO receive a result.
REQ-016 div_zero  out  1  one-cycle pulse, coincident with done, for a divide by zero.

Function
REQ-017 FSM states SHALL be IDLE, ITER, FIX and DONE, with a 5-bit iteration counter.
REQ-018 IDLE/DONE + start: on that edge, latch op and operand magnitudes (absolute values for MULT/DIV, raw values for MULTU/DIVU), record the result signs, load counter=31, and go to ITER.
REQ-019 ITER: one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle; counter decrements; at counter==0 the FSM goes to FIX, giving exactly 32 ITER cycles.
REQ-020 FIX: apply signs; MULT negates the 64-bit product if the signs differ; DIV negates the quotient if the signs differ and gives the remainder the sign of the dividend; then go to DONE.
REQ-021 Transition FIX->DONE: HI SHALL receive the product[63:32] or the remainder, and LO SHALL receive the product[31:0] or the quotient.
REQ-022 DONE lasts one cycle: done=1, then IDLE, or ITER if start is high.
REQ-023 Latency: start at edge k gives busy=1 in cycles k+1..k+33, done=1 in cycle k+34, and the new HI/LO visible on hl_rdata from cycle k+34.
REQ-024 busy=1 exactly in ITER and FIX.
REQ-025 stall = busy & (start | mf_rd | mt_we).
REQ-026 start while busy: ignored, with no effect on the FSM or operands.
REQ-027 mt_we while busy: ignored.
REQ-028 mt_we when not busy: writes mt_data to the HI/LO register selected by hl_sel on the edge.
REQ-029 mt_we in a DONE cycle: takes precedence over the result for the register it targets; the other register keeps the result.
REQ-030 start and mt_we together when not busy: the mt write completes and the operation starts on the same edge.
REQ-031 Divide by zero (DIV/DIVU with rt_data=0): same latency; HI=dividend as given (rs_data), LO=32'hFFFF_FFFF; div_zero=1 with done.
REQ-032 DIV with 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0, div_zero=0.
REQ-033 Multiply results SHALL be exact in 64 bits for all operand values.
REQ-034 A DIV/DIVU remainder SHALL satisfy |remainder| < |divisor|.

Reset
REQ-035 Reset: rst=1 at an edge forces IDLE, counter=0, HI=0, LO=0, busy=0, stall=0, done=0, div_zero=0.
REQ-036 rst asserted mid-operation aborts the operation with no HI/LO update and no done pulse.
REQ-037 rst SHALL take precedence over start and mt_we.

Verification
REQ-038 MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> after 34 cycles done=1, HI=0xFFFF_FFFE, LO=0x0000_0001.
REQ-039 MULT -7 x 3 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; DIV -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
REQ-040 DIVU 100/0 -> HI=100, LO=0xFFFF_FFFF, div_zero=1 with done; DIV 0x8000_0000/-1 -> LO=0x8000_0000, HI=0.
REQ-041 mf_rd held from cycle 5 of an op -> stall=1 until the DONE cycle; hl_rdata shows the new result in the DONE cycle.
REQ-042 rst pulsed in cycle 10 of a DIVU 50/7 -> busy=0 next cycle, HI=LO=0, no done; a new MULTU 6x7 then gives LO=42.
REQ-043 Back-to-back: start held through DONE -> second op accepted in the DONE cycle, second done exactly 34 cycles later; mt_we(HI, 0x1234) in the first DONE cycle -> HI=0x1234, LO=first result.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One shift-add or restoring subtract-shift step per cycle. A start is accepted
// in IDLE or DONE, and the result lands in HI/LO 34 cycles after it.
`timescale 1ns/1ps

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mf_rd,
    input  logic             mt_we,
    input  logic             hl_sel,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hl_rdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    // state | meaning
    // IDLE  | waiting for start; mt writes allowed
    // ITER  | 32 multiply/divide steps, counter 31 down to 0
    // FIX   | sign correction, result written to HI/LO on exit
    // DONE  | one-cycle done pulse; start or mt write allowed
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [4:0]         cnt_q;
    logic               is_div_q;
    logic               dz_q;
    logic               neg_q_q;     // negate product / quotient
    logic               neg_r_q;     // negate remainder
    logic [WIDTH-1:0]   acc_hi_q;    // partial product high half / remainder
    logic [WIDTH-1:0]   acc_lo_q;    // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0]   opb_q;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi_d;
    logic [WIDTH-1:0]   step_lo_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi_d;
    logic [WIDTH-1:0]   fix_lo_d;
    logic               unused_diff_bit;

    // Operand magnitudes and signs for the op being issued this cycle.
    always_comb begin
        a_neg = ~op[0] & rs_data[WIDTH-1];
        b_neg = ~op[0] & rt_data[WIDTH-1];
        a_mag = a_neg ? -rs_data : rs_data;
        b_mag = b_neg ? -rt_data : rt_data;
    end

    // One iteration step: shift-add for multiply, restoring subtract-shift for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        div_ge    = ~div_diff[WIDTH+1];
        if (is_div_q) begin
            step_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi_d = mul_sum[WIDTH:1];
            step_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // The remainder is always below 2^WIDTH, so this bit of the difference is never needed.
    assign unused_diff_bit = div_diff[WIDTH];

    // Sign correction applied on the FIX -> DONE edge.
    // With a zero divisor the raw remainder equals |dividend|, so restoring the
    // dividend sign gives back rs_data exactly; only LO needs forcing.
    always_comb begin
        prod_fix = neg_q_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quo_fix  = neg_q_q ? -acc_lo_q : acc_lo_q;
        rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;
        if (is_div_q) begin
            fix_hi_d = rem_fix;
            fix_lo_d = dz_q ? '1 : quo_fix;
        end else begin
            fix_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo_d = prod_fix[WIDTH-1:0];
        end
    end

    // Sequencer FSM, datapath registers, HI/LO and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (mt_we) begin
                        if (hl_sel) hi_q <= mt_data;
                        else        lo_q <= mt_data;
                    end
                    if (start) begin
                        is_div_q <= op[1];
                        dz_q     <= op[1] & (rt_data == '0);
                        neg_q_q  <= a_neg ^ b_neg;
                        neg_r_q  <= op[1] & a_neg;
                        acc_hi_q <= '0;
                        acc_lo_q <= op[1] ? a_mag : b_mag;
                        opb_q    <= op[1] ? b_mag : a_mag;
                        cnt_q    <= 5'd31;
                        busy_q   <= 1'b1;
                        state_q  <= S_ITER;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_ITER: begin
                    acc_hi_q <= step_hi_d;
                    acc_lo_q <= step_lo_d;
                    cnt_q    <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q       <= fix_hi_d;
                    lo_q       <= fix_lo_d;
                    done_q     <= 1'b1;
                    div_zero_q <= dz_q;
                    busy_q     <= 1'b0;
                    state_q    <= S_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hl_rdata = hl_sel ? hi_q : lo_q;
    assign busy     = busy_q;
    assign stall    = busy_q & (start | mf_rd | mt_we);
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer with hand-computed expected results.
`timescale 1ns/1ps

module tb_muldiv_sequencer;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        mf_rd = 1'b0;
    logic        mt_we = 1'b0;
    logic        hl_sel = 1'b0;
    logic [31:0] mt_data = '0;
    logic [31:0] hl_rdata;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .mf_rd    (mf_rd),
        .mt_we    (mt_we),
        .hl_sel   (hl_sel),
        .mt_data  (mt_data),
        .hl_rdata (hl_rdata),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Present an op for exactly one rising edge (edge k); returns just after that edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait (bounded) for done; lat = cycles after the issuing edge, -1 on timeout.
    task automatic wait_done(output int lat, output int busy_bad, output logic dz);
        lat = -1; busy_bad = 0; dz = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                dz  = div_zero;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic rd(input logic sel, output logic [31:0] v);
        hl_sel = sel;
        #1 v = hl_rdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b1; start = 1'b1; mt_we = 1'b1; hl_sel = 1'b1; mt_data = 32'hFFFF_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_done: got done=%b dz=%b want 0 0", done, div_zero); end
        start = 1'b0; mt_we = 1'b0; rst = 1'b0;
        rd(1'b1, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 00000000", v); end
        rd(1'b0, v);
        n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 00000000", v); end
    endtask

    task automatic test_mt_write;
        logic [31:0] v;
        @(negedge clk); mt_we = 1'b1; hl_sel = 1'b1; mt_data = 32'hAAAA_5555;
        @(negedge clk); hl_sel = 1'b0; mt_data = 32'h1234_5678;
        @(negedge clk); mt_we = 1'b0;
        rd(1'b1, v);
        n_checks++; if (v !== 32'hAAAA_5555) begin n_fail++; $display("FAIL mt_hi: got %h want aaaa5555", v); end
        rd(1'b0, v);
        n_checks++; if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL mt_lo: got %h want 12345678", v); end
    endtask

    // Arithmetic vectors: op, rs, rt, expected HI, expected LO, expected div_zero.
    task automatic test_arith;
        logic [1:0]  t_op [10];
        logic [31:0] t_a  [10];
        logic [31:0] t_b  [10];
        logic [31:0] t_hi [10];
        logic [31:0] t_lo [10];
        logic        t_dz [10];
        logic [31:0] v;
        int lat, bb;
        logic dz;
        t_op[0] = OP_MULTU; t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'hFFFF_FFFF; t_hi[0] = 32'hFFFF_FFFE; t_lo[0] = 32'h0000_0001; t_dz[0] = 1'b0;
        t_op[1] = OP_MULT;  t_a[1] = 32'hFFFF_FFF9; t_b[1] = 32'd3;         t_hi[1] = 32'hFFFF_FFFF; t_lo[1] = 32'hFFFF_FFEB; t_dz[1] = 1'b0;
        t_op[2] = OP_MULT;  t_a[2] = 32'h8000_0000; t_b[2] = 32'h8000_0000; t_hi[2] = 32'h4000_0000; t_lo[2] = 32'h0000_0000; t_dz[2] = 1'b0;
        t_op[3] = OP_MULT;  t_a[3] = 32'd12345;     t_b[3] = 32'hFFFF_FFFF; t_hi[3] = 32'hFFFF_FFFF; t_lo[3] = 32'hFFFF_CFC7; t_dz[3] = 1'b0;
        t_op[4] = OP_DIV;   t_a[4] = 32'hFFFF_FFF9; t_b[4] = 32'd2;         t_hi[4] = 32'hFFFF_FFFF; t_lo[4] = 32'hFFFF_FFFD; t_dz[4] = 1'b0;
        t_op[5] = OP_DIV;   t_a[5] = 32'd7;         t_b[5] = 32'hFFFF_FFFE; t_hi[5] = 32'd1;         t_lo[5] = 32'hFFFF_FFFD; t_dz[5] = 1'b0;
        t_op[6] = OP_DIV;   t_a[6] = 32'h8000_0000; t_b[6] = 32'hFFFF_FFFF; t_hi[6] = 32'd0;         t_lo[6] = 32'h8000_0000; t_dz[6] = 1'b0;
        t_op[7] = OP_DIVU;  t_a[7] = 32'hFFFF_FFFF; t_b[7] = 32'h10;        t_hi[7] = 32'hF;         t_lo[7] = 32'h0FFF_FFFF; t_dz[7] = 1'b0;
        t_op[8] = OP_DIVU;  t_a[8] = 32'd100;       t_b[8] = 32'd0;         t_hi[8] = 32'd100;       t_lo[8] = 32'hFFFF_FFFF; t_dz[8] = 1'b1;
        t_op[9] = OP_DIV;   t_a[9] = 32'hFFFF_FFFB; t_b[9] = 32'd0;         t_hi[9] = 32'hFFFF_FFFB; t_lo[9] = 32'hFFFF_FFFF; t_dz[9] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(lat, bb, dz);
            n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL arith%0d_latency: got %0d want 34", i, lat); end
            n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL arith%0d_busy: %0d bad cycles want 0", i, bb); end
            n_checks++; if (dz !== t_dz[i]) begin n_fail++; $display("FAIL arith%0d_divzero: got %b want %b", i, dz, t_dz[i]); end
            rd(1'b1, v);
            n_checks++; if (v !== t_hi[i]) begin n_fail++; $display("FAIL arith%0d_hi: got %h want %h", i, v, t_hi[i]); end
            rd(1'b0, v);
            n_checks++; if (v !== t_lo[i]) begin n_fail++; $display("FAIL arith%0d_lo: got %h want %h", i, v, t_lo[i]); end
            @(negedge clk);
            n_checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL arith%0d_pulse: got done=%b dz=%b want 0 0", i, done, div_zero); end
        end
    endtask

    // mf_rd held from cycle 5; start and mt_we pulsed while busy must be ignored.
    task automatic test_stall;
        logic [31:0] v;
        int stall_bad = 0;
        int busy_bad = 0;
        issue(OP_MULTU, 32'd3, 32'd5);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 5)  mf_rd = 1'b1;
            if (c == 10) begin start = 1'b1; op = OP_DIV; rs_data = 32'd1; rt_data = 32'd1; end
            if (c == 11) start = 1'b0;
            if (c == 12) begin mt_we = 1'b1; hl_sel = 1'b0; mt_data = 32'hDEAD_BEEF; end
            if (c == 13) mt_we = 1'b0;
            #1;
            if (stall !== (c >= 5)) stall_bad++;
            if (busy !== 1'b1) busy_bad++;
        end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL stall_window: %0d bad cycles want 0", stall_bad); end
        n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL stall_busy: %0d bad cycles want 0", busy_bad); end
        @(negedge clk);
        hl_sel = 1'b0;
        #1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b want 1", done); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_in_done: got %b want 0", stall); end
        n_checks++; if (hl_rdata !== 32'd15) begin n_fail++; $display("FAIL stall_lo_in_done: got %h want 0000000f", hl_rdata); end
        mf_rd = 1'b0;
        rd(1'b1, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL stall_hi: got %h want 00000000", v); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] v;
        int done_seen = 0;
        issue(OP_DIVU, 32'd50, 32'd7);
        repeat (9) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        rd(1'b1, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL abort_hi: got %h want 00000000", v); end
        rd(1'b0, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL abort_lo: got %h want 00000000", v); end
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen++;
        end
        n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL abort_no_done: saw %0d done cycles want 0", done_seen); end
        begin
            int lat, bb;
            logic dz;
            issue(OP_MULTU, 32'd6, 32'd7);
            wait_done(lat, bb, dz);
            n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 34", lat); end
            rd(1'b0, v);
            n_checks++; if (v !== 32'd42) begin n_fail++; $display("FAIL abort_next_lo: got %0d want 42", v); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        int lat, bb;
        logic dz;
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; rs_data = 32'd6; rt_data = 32'd7;
        @(posedge clk);
        #1 op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7;
        wait_done(lat, bb, dz);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 34", lat); end
        mt_we = 1'b1; hl_sel = 1'b1; mt_data = 32'h0000_1234;
        @(posedge clk);
        #1 start = 1'b0; mt_we = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
        rd(1'b1, v);
        n_checks++; if (v !== 32'h0000_1234) begin n_fail++; $display("FAIL b2b_mt_hi: got %h want 00001234", v); end
        rd(1'b0, v);
        n_checks++; if (v !== 32'd42) begin n_fail++; $display("FAIL b2b_first_lo: got %0d want 42", v); end
        // One cycle of the second op has already elapsed, so done is 33 more cycles out.
        wait_done(lat, bb, dz);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
        rd(1'b1, v);
        n_checks++; if (v !== 32'd2) begin n_fail++; $display("FAIL b2b_second_hi: got %0d want 2", v); end
        rd(1'b0, v);
        n_checks++; if (v !== 32'd14) begin n_fail++; $display("FAIL b2b_second_lo: got %0d want 14", v); end
    endtask

    initial begin
        test_reset();
        test_mt_write();
        test_arith();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
